// File: rtl/alu_seq_n.sv
// alu_seq_n: sequential ALU for the execute stage, between the operand
// register file and the write-back mux. Most opcodes finish in one cycle;
// MUL runs an iterative shift-add multiply over WIDTH cycles. Result and
// flags are registered and hold until the next completed operation.
//
// State table:
//   state  | meaning
//   S_IDLE | ready; start accepted; single-cycle ops complete here
//   S_MUL  | shift-add multiply in progress; start ignored
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      request, accepted when busy=0
//   op[3:0]    operation code, latched at accept
//   a, b       operands, latched at accept; b[SW-1:0] is the shift amount
//   result     registered result
//   c,n,z,v    registered carry/negative/zero/overflow flags
//   busy       high while a multiply is in progress
//   done       one-cycle pulse; result and flags valid from this cycle
module alu_seq_n #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_NOTA = 4'h0;
    localparam logic [3:0] OP_NOTB = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_XNOR = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_ADC  = 4'h8;
    localparam logic [3:0] OP_SBC  = 4'h9;
    localparam logic [3:0] OP_LSL  = 4'hA;
    localparam logic [3:0] OP_LSR  = 4'hB;
    localparam logic [3:0] OP_ASR  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;

    localparam logic [SW:0] CNT_INIT = (SW+1)'(WIDTH);
    localparam logic [SW:0] CNT_ONE  = (SW+1)'(1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               c_q, c_d, n_q, n_d, z_q, z_d, v_q, v_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SW:0]        cnt_q, cnt_d;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge.
    logic [SW-1:0]      sh;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH:0]     add_full;
    logic               msb_cin;
    logic [WIDTH:0]     lsl_full;
    logic [WIDTH:0]     lsr_full;
    logic [WIDTH:0]     asr_full;
    logic [2*WIDTH-1:0] acc_step;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_n, alu_z, alu_v;

    assign sh       = b[SW-1:0];
    assign add_b    = (op == OP_SUB || op == OP_SBC) ? ~b : b;
    assign add_cin  = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : c_q;
    assign add_full = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
    assign msb_cin  = add_full[WIDTH-1] ^ a[WIDTH-1] ^ add_b[WIDTH-1];

    // The extra bit beside the operand catches the last bit shifted out;
    // with a zero shift it stays 0, which gives c=0 for free.
    assign lsl_full = {1'b0, a} << sh;
    assign lsr_full = {a, 1'b0} >> sh;
    assign asr_full = $signed({a, 1'b0}) >>> sh;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_z   = 1'b0;
        unique case (op)
            OP_NOTA: alu_res = ~a;
            OP_NOTB: alu_res = ~b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_XNOR: alu_res = ~(a ^ b);
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = msb_cin ^ add_full[WIDTH];
            end
            OP_LSL: {alu_c, alu_res} = lsl_full;
            OP_LSR: {alu_res, alu_c} = lsr_full;
            OP_ASR: {alu_res, alu_c} = asr_full;
            default: alu_res = '0;
        endcase
        alu_n = alu_res[WIDTH-1];
        // Reserved opcodes report every flag clear, including z.
        if (op != 4'hE && op != 4'hF) begin
            alu_z = (alu_res == '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        c_d      = c_q;
        n_d      = n_q;
        z_d      = z_q;
        v_d      = v_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = CNT_INIT;
                        state_d  = S_MUL;
                    end else begin
                        result_d = alu_res;
                        c_d      = alu_c;
                        n_d      = alu_n;
                        z_d      = alu_z;
                        v_d      = alu_v;
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    result_d = acc_step[WIDTH-1:0];
                    n_d      = acc_step[WIDTH-1];
                    z_d      = (acc_step[WIDTH-1:0] == '0);
                    c_d      = |acc_step[2*WIDTH-1:WIDTH];
                    v_d      = |acc_step[2*WIDTH-1:WIDTH];
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            c_q      <= c_d;
            n_q      <= n_d;
            z_q      <= z_d;
            v_q      <= v_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign c      = c_q;
    assign n      = n_q;
    assign z      = z_q;
    assign v      = v_q;
    assign done   = done_q;
    assign busy   = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_seq_n.sv
module tb_alu_seq_n;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic         c, n, z, v, busy, done;

    int   n_asserts = 0;
    int   n_fail = 0;
    logic c_model = 1'b0;

    typedef struct packed {
        logic [7:0] r;
        logic c, n, z, v;
    } res_t;

    alu_seq_n #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .result(result), .c(c), .n(n), .z(z), .v(v), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on 8-bit values.
    function automatic res_t model(input int o, input int ia, input int ib, input int cin);
        res_t e;
        int r = 0, cf = 0, vf = 0, s = 0, p = 0, t = 0;
        int sa, sb, sh;
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        sh = ib % W;
        case (o)
            0:  r = (~ia) & 255;
            1:  r = (~ib) & 255;
            2:  r = ia & ib;
            3:  r = ia | ib;
            4:  r = ia ^ ib;
            5:  r = (~(ia ^ ib)) & 255;
            6:  begin s = ia + ib;             t = sa + sb; end
            7:  begin s = ia + (255 - ib) + 1; t = sa - sb; end
            8:  begin s = ia + ib + cin;       t = sa + sb + cin; end
            9:  begin s = ia + (255 - ib) + cin; t = sa - sb - 1 + cin; end
            10: begin r = (ia << sh) & 255; cf = (sh != 0) ? (ia >> (W - sh)) & 1 : 0; end
            11: begin r = ia >> sh;         cf = (sh != 0) ? (ia >> (sh - 1)) & 1 : 0; end
            12: begin r = (sa >>> sh) & 255; cf = (sh != 0) ? (sa >>> (sh - 1)) & 1 : 0; end
            13: begin p = ia * ib; r = p % 256; cf = (p / 256 != 0) ? 1 : 0; vf = cf; end
            default: r = 0;
        endcase
        if (o >= 6 && o <= 9) begin
            r  = s % 256;
            cf = (s > 255) ? 1 : 0;
            vf = (t > 127 || t < -128) ? 1 : 0;
        end
        e.r = 8'(r);
        e.c = (cf != 0);
        e.v = (vf != 0);
        e.n = ((r >> 7) & 1) != 0;
        e.z = (o < 14) && (r == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input res_t e);
        chk({tag, ".result"}, 64'(result), 64'(e.r));
        chk({tag, ".c"}, 64'(c), 64'(e.c));
        chk({tag, ".n"}, 64'(n), 64'(e.n));
        chk({tag, ".z"}, 64'(z), 64'(e.z));
        chk({tag, ".v"}, 64'(v), 64'(e.v));
    endtask

    task automatic do_op(input int o, input int ia, input int ib);
        res_t  e;
        string tag;
        e   = model(o, ia, ib, int'(c_model));
        tag = $sformatf("op%0h_%0h_%0h", o, ia, ib);
        @(negedge clk);
        start = 1'b1;
        op    = 4'(o);
        a     = W'(ia);
        b     = W'(ib);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".done"}, 64'(done), 64'(1));
        chk({tag, ".busy"}, 64'(busy), 64'(0));
        chk_out(tag, e);
        c_model = e.c;
    endtask

    task automatic do_mul(input int ia, input int ib, input bit inject);
        res_t  e;
        string tag;
        e   = model(13, ia, ib, int'(c_model));
        tag = $sformatf("mul_%0h_%0h", ia, ib);
        @(negedge clk);
        start = 1'b1;
        op    = 4'hD;
        a     = W'(ia);
        b     = W'(ib);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".acc_busy"}, 64'(busy), 64'(1));
        chk({tag, ".acc_done"}, 64'(done), 64'(0));
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (inject && k == 4) begin
                start = 1'b1;
                op    = 4'h6;
                a     = W'(1);
                b     = W'(1);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k < W) begin
                chk($sformatf("%s.busy%0d", tag, k), 64'(busy), 64'(1));
                chk($sformatf("%s.done%0d", tag, k), 64'(done), 64'(0));
            end else begin
                chk({tag, ".fin_done"}, 64'(done), 64'(1));
                chk({tag, ".fin_busy"}, 64'(busy), 64'(0));
                chk_out(tag, e);
            end
        end
        c_model = e.c;
        @(posedge clk);
        #1;
        chk({tag, ".done_after"}, 64'(done), 64'(0));
        chk({tag, ".held"}, 64'(result), 64'(e.r));
    endtask

    initial begin
        logic saw_done;
        int   o, ia, ib;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.result", 64'(result), 64'(0));
        chk("rst.flags", 64'({c, n, z, v}), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // ADD overflow into the sign bit, then done must drop
        do_op(6, 'h7F, 'h01);
        chk("add7f.result", 64'(result), 64'(8'h80));
        chk("add7f.ncvz", 64'({n, c, v, z}), 64'(4'b1010));
        @(posedge clk);
        #1;
        chk("add7f.done_pulse", 64'(done), 64'(0));
        chk("add7f.hold", 64'(result), 64'(8'h80));

        do_op(7, 'h05, 'h05);
        chk("sub55.zcv", 64'({z, c, v}), 64'(3'b110));
        do_op(7, 'h00, 'h01);
        chk("sub01.result", 64'(result), 64'(8'hFF));
        chk("sub01.cn", 64'({c, n}), 64'(2'b01));

        // Back-to-back carry chain
        do_op(6, 'hFF, 'h01);
        chk("addff.c", 64'(c), 64'(1));
        do_op(8, 'h00, 'h00);
        chk("adc.result", 64'(result), 64'(8'h01));
        chk("adc.c", 64'(c), 64'(0));

        do_op(12, 'h80, 'h03);
        chk("asr.result", 64'(result), 64'(8'hF0));
        do_op(11, 'h81, 'h01);
        chk("lsr.result_c", 64'({result, c}), 64'({8'h40, 1'b1}));
        do_op(10, 'h81, 'h00);
        chk("lsl0.result_c", 64'({result, c}), 64'({8'h81, 1'b0}));
        do_op(14, 'h12, 'h34);
        do_op(15, 'h00, 'h00);

        do_mul('h0F, 'h11, 1'b1);
        chk("mul0f.result", 64'(result), 64'(8'hFF));
        do_mul('h10, 'h10, 1'b0);
        chk("mul10.zcv", 64'({z, c, v}), 64'(3'b111));

        // Reset during a multiply
        do_op(6, 'h21, 'h10);
        @(negedge clk);
        start = 1'b1;
        op    = 4'hD;
        a     = W'(8'h0F);
        b     = W'(8'h11);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst.busy", 64'(busy), 64'(0));
        chk("midrst.result", 64'(result), 64'(0));
        chk("midrst.flags", 64'({c, n, z, v}), 64'(0));
        chk("midrst.done", 64'(done), 64'(0));
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        @(negedge clk);
        reset_n = 1'b1;
        c_model = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            saw_done |= done | busy;
        end
        chk("midrst.no_done", 64'(saw_done), 64'(0));
        do_op(6, 'h02, 'h03);
        chk("post_rst.add", 64'(result), 64'(8'h05));

        // Random operations against the model
        for (int i = 0; i < 150; i++) begin
            o  = int'($urandom_range(0, 15));
            ia = int'($urandom_range(0, 255));
            ib = int'($urandom_range(0, 255));
            if (o == 13) begin
                do_mul(ia, ib, 1'b0);
            end else begin
                do_op(o, ia, ib);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
